io_response_collector: RTL and testbench
========================================

Name: io_response_collector

Overview:
- Peripheral-to-CPU return path of the I/O bus.
- The I/O address decoder fans one CPU data-master access out to N per-peripheral select lines. This block gathers the per-peripheral ack and read-data lines back into one data_m_ack / data_m_data_in for the CPU.
- It also answers accesses that no peripheral claims (default I/O) with all-ones data, and enforces a timeout so a hung peripheral cannot stall the bus.
- Sits between the peripheral array and the CPU data-master port.

Parameters:
- NUM_PERIPH, 13, number of select/ack/data lanes (lane order matches decoder outputs).
- TIMEOUT_CYCLES, 255, cycles from access start to forced completion; legal range 2..65535.
- DEFAULT_DATA, 16'hFFFF, read data returned for unclaimed or timed-out accesses.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- d_io  in  1  current access is I/O space.
- data_m_access  in  1  CPU access request; held high until data_m_ack.
- data_m_wr_en  in  1  1 = write, 0 = read.
- data_m_addr  in  19  word address [19:1]; captured for the error log.
- periph_sel  in  NUM_PERIPH  one-hot select vector from the decoder.
- periph_ack  in  NUM_PERIPH  per-peripheral single-cycle ack.
- periph_data  in  16*NUM_PERIPH  per-peripheral read data; lane i occupies [16i+15:16i].
- data_m_ack  out  1  single-cycle completion to the CPU.
- data_m_data_in  out  16  read data, valid in the data_m_ack cycle.
- bus_error  out  1  single-cycle pulse on timeout or multi-select.
- err_addr  out  19  address of the last errored access.
- err_count  out  8  saturating error count.

Behaviour:
- Reset (async, reset_n low): FSM to IDLE; data_m_ack=0, data_m_data_in=0, bus_error=0, err_addr=0, err_count=0; timeout counter=0.
- All outputs are registered.
- An access is active when d_io & data_m_access. Memory-space accesses (d_io=0) are ignored entirely.

FSM IDLE:
- On an active access, evaluate periph_sel:
  - popcount 0 → DEFAULT.
  - popcount 1 → WAIT; latch the lane index.
  - popcount >1 → ERROR.
- Load the timeout counter to 1.

FSM WAIT:
- Each cycle, check periph_ack of the latched lane.
- If high: next cycle data_m_ack=1, and data_m_data_in = that lane's data (read) or 0 (write). Then go to DONE.
- Latency: ack registered on edge k gives data_m_ack high after edge k+1 (1 cycle).
- Acks on non-latched lanes are ignored.
- Counter increments each cycle. When it reaches TIMEOUT_CYCLES without ack, go to ERROR.
- A lane ack arriving in the same cycle the counter hits TIMEOUT_CYCLES wins: normal completion, no error.

FSM DEFAULT:
- One cycle later, data_m_ack=1 with data_m_data_in=DEFAULT_DATA on reads, 0 on writes.
- bus_error stays 0. Go to DONE.

FSM ERROR:
- data_m_ack=1 and bus_error=1 for exactly 1 cycle.
- data_m_data_in=DEFAULT_DATA on reads, 0 on writes.
- Go to DONE.

FSM DONE:
- Outputs return to data_m_ack=0, bus_error=0. data_m_data_in holds its value.
- Wait one cycle, then return to IDLE. This guards against re-triggering while the CPU drops data_m_access.
- The earliest next accept is 2 cycles after data_m_ack.

Further rules:
- If data_m_access drops in WAIT before any ack (aborted access), return to IDLE without data_m_ack or bus_error.
- If reset_n is asserted mid-access, everything clears immediately. A late periph_ack after reset release is ignored while in IDLE.

Optional Feature:
- Macro IO_ERROR_LOG_EN.
- Defined: on each bus_error pulse, err_addr latches data_m_addr of the failing access and err_count increments, saturating at 255. Both clear only on reset.
- Undefined: err_addr and err_count are tied to 0 and no log registers are generated. bus_error behaviour is unchanged.

Test Plan:
1. Read, lane 9 selected, periph_ack lane 9 high 3 cycles after access with data 16'h1234 → data_m_ack exactly 1 cycle, 1 cycle after ack; data_m_data_in=16'h1234; bus_error=0.
2. Read with periph_sel=0 at addr 19'h7FFF → data_m_ack 2 cycles after access; data=16'hFFFF; bus_error=0.
3. Read on lane 2, no ack, TIMEOUT_CYCLES=8 → data_m_ack with bus_error pulse; data=16'hFFFF; with IO_ERROR_LOG_EN, err_addr=access address and err_count=1.
4. periph_sel=13'b0000000000011 → immediate ERROR path; bus_error=1; err_count increments. Then 300 forced timeouts → err_count saturates at 255.
5. Write on lane 0 with ack in the same cycle the timeout is reached → normal completion, bus_error=0, data_m_data_in=0.
6. reset_n asserted while in WAIT, lane 4 acks 1 cycle after release → no data_m_ack; all outputs 0; the next access completes normally.

Source files
------------

// File: rtl/io_response_collector.sv
// io_response_collector: gathers per-peripheral ack/read data into one CPU
// data-master completion, answers unclaimed I/O accesses with DEFAULT_DATA
// and forces completion with bus_error on timeout or multi-select.
// Ports: clk, reset_n (async, active low); CPU side d_io, data_m_access,
// data_m_wr_en, data_m_addr -> data_m_ack, data_m_data_in; peripheral side
// periph_sel, periph_ack, periph_data; status bus_error, err_addr, err_count.
// Optional error log (err_addr/err_count) enabled by macro IO_ERROR_LOG_EN.
module io_response_collector #(
    parameter int          NUM_PERIPH     = 13,
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [15:0] DEFAULT_DATA   = 16'hFFFF
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     d_io,
    input  logic                     data_m_access,
    input  logic                     data_m_wr_en,
    input  logic [18:0]              data_m_addr,
    input  logic [NUM_PERIPH-1:0]    periph_sel,
    input  logic [NUM_PERIPH-1:0]    periph_ack,
    input  logic [16*NUM_PERIPH-1:0] periph_data,
    output logic                     data_m_ack,
    output logic [15:0]              data_m_data_in,
    output logic                     bus_error,
    output logic [18:0]              err_addr,
    output logic [7:0]               err_count
);

    localparam int          LW = (NUM_PERIPH > 1) ? $clog2(NUM_PERIPH) : 1;
    localparam logic [15:0] TO = 16'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DEFAULT,
        S_ERROR,
        S_DONE
    } state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] lane_q, lane_d;
    logic          wr_q, wr_d;
    logic [15:0]   cnt_q, cnt_d;
    logic          ack_q, ack_d;
    logic [15:0]   data_q, data_d;
    logic          berr_q, berr_d;

    logic          access_act;
    logic          sel_seen;
    logic          sel_multi;
    logic [LW-1:0] sel_idx;
    logic          lane_ack;
    logic [15:0]   lane_data;

    assign access_act = d_io & data_m_access;

    // Select decode: index of the claimed lane, plus none/multiple flags.
    always_comb begin
        sel_seen  = 1'b0;
        sel_multi = 1'b0;
        sel_idx   = '0;
        for (int i = 0; i < NUM_PERIPH; i++) begin
            if (periph_sel[i]) begin
                if (sel_seen) begin
                    sel_multi = 1'b1;
                end
                sel_seen = 1'b1;
                sel_idx  = LW'(i);
            end
        end
    end

    // Only the latched lane is observed; acks on other lanes are ignored.
    always_comb begin
        lane_ack  = 1'b0;
        lane_data = '0;
        for (int i = 0; i < NUM_PERIPH; i++) begin
            if (LW'(i) == lane_q) begin
                lane_ack  = periph_ack[i];
                lane_data = periph_data[i*16 +: 16];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        berr_d  = 1'b0;
        data_d  = data_q;
        unique case (state_q)
            S_IDLE: begin
                if (access_act) begin
                    wr_d   = data_m_wr_en;
                    cnt_d  = 16'd1;
                    lane_d = sel_idx;
                    if (sel_multi) begin
                        state_d = S_ERROR;
                    end else if (!sel_seen) begin
                        state_d = S_DEFAULT;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (!data_m_access) begin
                    // CPU abandoned the access: leave silently.
                    state_d = S_IDLE;
                end else if (lane_ack) begin
                    // Ack beats the timeout when both land together.
                    ack_d   = 1'b1;
                    data_d  = wr_q ? 16'h0000 : lane_data;
                    state_d = S_DONE;
                end else if (cnt_q >= TO) begin
                    state_d = S_ERROR;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DEFAULT: begin
                ack_d   = 1'b1;
                data_d  = wr_q ? 16'h0000 : DEFAULT_DATA;
                state_d = S_DONE;
            end
            S_ERROR: begin
                ack_d   = 1'b1;
                berr_d  = 1'b1;
                data_d  = wr_q ? 16'h0000 : DEFAULT_DATA;
                state_d = S_DONE;
            end
            S_DONE: begin
                // One dead cycle so a still-high access is not re-accepted.
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            lane_q  <= '0;
            wr_q    <= 1'b0;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
            data_q  <= '0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lane_q  <= lane_d;
            wr_q    <= wr_d;
            cnt_q   <= cnt_d;
            ack_q   <= ack_d;
            data_q  <= data_d;
            berr_q  <= berr_d;
        end
    end

    assign data_m_ack     = ack_q;
    assign data_m_data_in = data_q;
    assign bus_error      = berr_q;

`ifdef IO_ERROR_LOG_EN
    logic [18:0] err_addr_q, err_addr_d;
    logic [7:0]  err_count_q, err_count_d;

    // The CPU holds its address until ack, so the live address in the
    // ERROR state still belongs to the failing access.
    always_comb begin
        err_addr_d  = err_addr_q;
        err_count_d = err_count_q;
        if (state_q == S_ERROR) begin
            err_addr_d = data_m_addr;
            if (err_count_q != 8'hFF) begin
                err_count_d = err_count_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            err_addr_q  <= '0;
            err_count_q <= '0;
        end else begin
            err_addr_q  <= err_addr_d;
            err_count_q <= err_count_d;
        end
    end

    assign err_addr  = err_addr_q;
    assign err_count = err_count_q;
`else
    logic unused_addr;
    assign unused_addr = ^data_m_addr;
    assign err_addr    = '0;
    assign err_count   = '0;
`endif

endmodule

// File: tb/tb_io_response_collector.sv
// tb_io_response_collector: directed self-checking bench for
// io_response_collector (TIMEOUT_CYCLES=8), log checks follow IO_ERROR_LOG_EN.
module tb_io_response_collector;

    localparam int NP = 13;
    localparam int TO = 8;
`ifdef IO_ERROR_LOG_EN
    localparam bit LOG_EN = 1'b1;
`else
    localparam bit LOG_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_n;
    logic            d_io;
    logic            data_m_access;
    logic            data_m_wr_en;
    logic [18:0]     data_m_addr;
    logic [NP-1:0]   periph_sel;
    logic [NP-1:0]   periph_ack;
    logic [16*NP-1:0] periph_data;
    logic            data_m_ack;
    logic [15:0]     data_m_data_in;
    logic            bus_error;
    logic [18:0]     err_addr;
    logic [7:0]      err_count;

    int          vectors = 0;
    int          miscompares = 0;
    int          exp_cnt = 0;
    logic [18:0] exp_addr = '0;

    always #5 clk = ~clk;

    io_response_collector #(
        .NUM_PERIPH    (NP),
        .TIMEOUT_CYCLES(TO),
        .DEFAULT_DATA  (16'hFFFF)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .d_io          (d_io),
        .data_m_access (data_m_access),
        .data_m_wr_en  (data_m_wr_en),
        .data_m_addr   (data_m_addr),
        .periph_sel    (periph_sel),
        .periph_ack    (periph_ack),
        .periph_data   (periph_data),
        .data_m_ack    (data_m_ack),
        .data_m_data_in(data_m_data_in),
        .bus_error     (bus_error),
        .err_addr      (err_addr),
        .err_count     (err_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic chk_log(input string tag);
        chk({tag, "_eaddr"}, 32'(err_addr), LOG_EN ? 32'(exp_addr) : 32'd0);
        chk({tag, "_ecnt"}, 32'(err_count), LOG_EN ? 32'(exp_cnt) : 32'd0);
    endtask

    // One CPU access; ack_at = negedge index after which the lane acks
    // (0 = never). Checks latency, ack width, data and error outputs.
    task automatic run_access(input string tag, input logic [NP-1:0] sel,
                              input logic [NP-1:0] ackv, input logic wr,
                              input logic [18:0] addr, input int ack_at,
                              input int exp_lat, input logic exp_berr,
                              input logic [15:0] exp_data);
        int          lat;
        logic        got;
        logic        berr_s;
        logic [15:0] data_s;
        d_io          = 1'b1;
        data_m_access = 1'b1;
        data_m_wr_en  = wr;
        data_m_addr   = addr;
        periph_sel    = sel;
        periph_ack    = '0;
        lat    = 0;
        got    = 1'b0;
        berr_s = 1'b0;
        data_s = '0;
        while (!got && lat < 40) begin
            step();
            lat++;
            periph_ack = '0;
            if (data_m_ack) begin
                got    = 1'b1;
                berr_s = bus_error;
                data_s = data_m_data_in;
            end else if (lat == ack_at) begin
                periph_ack = ackv;
            end
        end
        if (exp_berr) begin
            if (exp_cnt < 255) exp_cnt++;
            exp_addr = addr;
        end
        chk({tag, "_acked"}, 32'(got), 32'd1);
        chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({tag, "_berr"}, 32'(berr_s), 32'(exp_berr));
        chk({tag, "_data"}, 32'(data_s), 32'(exp_data));
        chk_log(tag);
        data_m_access = 1'b0;
        d_io          = 1'b0;
        periph_sel    = '0;
        step();
        chk({tag, "_ack_drop"}, 32'(data_m_ack), 32'd0);
        chk({tag, "_berr_drop"}, 32'(bus_error), 32'd0);
        chk({tag, "_data_hold"}, 32'(data_m_data_in), 32'(exp_data));
    endtask

    initial begin
        logic seen;
        reset_n       = 1'b0;
        d_io          = 1'b0;
        data_m_access = 1'b0;
        data_m_wr_en  = 1'b0;
        data_m_addr   = '0;
        periph_sel    = '0;
        periph_ack    = '0;
        for (int i = 0; i < NP; i++) begin
            periph_data[i*16 +: 16] = 16'hA000 | 16'(i);
        end
        step();
        step();
        chk("rst_ack", 32'(data_m_ack), 32'd0);
        chk("rst_data", 32'(data_m_data_in), 32'd0);
        chk("rst_berr", 32'(bus_error), 32'd0);
        chk_log("rst");
        reset_n = 1'b1;
        step();

        periph_data[9*16 +: 16] = 16'h1234;
        run_access("lane9_rd", 13'(1 << 9), 13'(1 << 9), 1'b0, 19'h01230,
                   3, 4, 1'b0, 16'h1234);
        run_access("unclaimed_rd", '0, '0, 1'b0, 19'h07FFF,
                   0, 2, 1'b0, 16'hFFFF);
        run_access("unclaimed_wr", '0, '0, 1'b1, 19'h07FFE,
                   0, 2, 1'b0, 16'h0000);
        run_access("timeout_rd", 13'(1 << 2), '0, 1'b0, 19'h2ABCD,
                   0, 10, 1'b1, 16'hFFFF);

        // Abort after a wrong-lane ack: nothing may come back.
        d_io          = 1'b1;
        data_m_access = 1'b1;
        data_m_wr_en  = 1'b0;
        data_m_addr   = 19'h00555;
        periph_sel    = 13'(1 << 5);
        step();
        step();
        periph_ack = 13'(1 << 6);
        step();
        periph_ack = '0;
        step();
        chk("abort_pre", 32'(data_m_ack), 32'd0);
        data_m_access = 1'b0;
        d_io          = 1'b0;
        periph_sel    = '0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            seen = seen | data_m_ack | bus_error;
        end
        chk("abort_quiet", 32'(seen), 32'd0);

        run_access("ack_at_to_wr", 13'b1, 13'b1, 1'b1, 19'h00100,
                   TO, TO + 1, 1'b0, 16'h0000);
        run_access("ack_late_rd", 13'b1, 13'b1, 1'b0, 19'h00200,
                   TO + 1, TO + 2, 1'b1, 16'hFFFF);
        run_access("multi_sel", 13'b11, 13'b11, 1'b0, 19'h00011,
                   1, 2, 1'b1, 16'hFFFF);

        for (int i = 0; i < 300; i++) begin
            run_access("sat", 13'(1 << 2), '0, 1'b0, 19'(i + 1),
                       0, TO + 2, 1'b1, 16'hFFFF);
        end
        chk("sat_final", 32'(err_count), LOG_EN ? 32'd255 : 32'd0);

        // Reset mid-WAIT, then a stray ack from lane 4 after release.
        d_io          = 1'b1;
        data_m_access = 1'b1;
        data_m_wr_en  = 1'b0;
        data_m_addr   = 19'h00444;
        periph_sel    = 13'(1 << 4);
        step();
        step();
        reset_n       = 1'b0;
        data_m_access = 1'b0;
        d_io          = 1'b0;
        periph_sel    = '0;
        #1;
        chk("midrst_ack", 32'(data_m_ack), 32'd0);
        chk("midrst_data", 32'(data_m_data_in), 32'd0);
        chk("midrst_berr", 32'(bus_error), 32'd0);
        chk("midrst_eaddr", 32'(err_addr), 32'd0);
        chk("midrst_ecnt", 32'(err_count), 32'd0);
        exp_cnt  = 0;
        exp_addr = '0;
        step();
        reset_n = 1'b1;
        step();
        periph_ack = 13'(1 << 4);
        step();
        periph_ack = '0;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            seen = seen | data_m_ack | bus_error;
        end
        chk("late_ack_quiet", 32'(seen), 32'd0);
        run_access("post_rst", 13'(1 << 4), 13'(1 << 4), 1'b0, 19'h00404,
                   1, 2, 1'b0, 16'hA004);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
